prod_acc: RTL and testbench

PROD_ACC -- requirements
Module: prod_acc

---
 rtl/prod_acc_pkg.sv | 13 +
 rtl/prod_acc_sat_add.sv | 29 ++
 rtl/prod_acc.sv | 94 +++++++++
 tb/tb_prod_acc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// Shared constants and types for the product accumulator.
package prod_acc_pkg;

    // Width of one signed product from the upstream 8x8 multiplier.
    localparam int PROD_W = 16;

    // ACCUM gathers products; HOLD presents a finished block sum.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/prod_acc_sat_add.sv
// Signed W-bit adder with overflow flag.
// Macro PROD_ACC_SAT_EN: when defined, an overflowing sum clamps to the
// signed extreme matching the operand sign; otherwise the sum wraps.
module sat_add #(
    parameter int W = 24
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W-1:0] raw;

    // Overflow: operands agree in sign but the raw sum does not.
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef PROD_ACC_SAT_EN
        if (ovf)
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sum = raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/prod_acc.sv
// Block accumulator: sums LEN signed products into one ACC_W-bit result
// with a sticky signed-overflow flag, handed out over a valid/ready port.
// Optional macro PROD_ACC_SAT_EN (saturating add) lives in sat_add.
module prod_acc
    import prod_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     out_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic                    sticky;
    logic                    add_ovf;
    logic                    in_xfer;
    logic                    last;

    // Size cast of a signed operand sign-extends the product.
    assign p_ext   = ACC_W'(in_p);
    // Derived from state directly so the FSM comb block has no loop through in_ready.
    assign in_xfer = in_valid && (state == ACCUM);
    assign last    = (cnt == CNT_W'(LEN - 1));

    sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (p_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulate on each accepted product; the last one of a block lands
    // in the output register and leaves the running state clear for the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else if (in_xfer) begin
            if (last) begin
                out_acc <= sum;
                out_ovf <= sticky | add_ovf;
                acc     <= '0;
                cnt     <= '0;
                sticky  <= 1'b0;
            end else begin
                acc     <= sum;
                cnt     <= cnt + CNT_W'(1);
                sticky  <= sticky | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_prod_acc.sv
// Self-checking bench for prod_acc: directed table, backpressure, bubbles,
// reset corners and a randomized run against an arithmetic reference model.
module tb_prod_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_p;
    logic               out_ready;

    // u0: defaults (ACC_W=24, LEN=16); u1: ACC_W=16, LEN=4. Inputs are shared.
    logic               in_ready0, out_valid0, out_ovf0;
    logic signed [23:0] out_acc0;
    logic               in_ready1, out_valid1, out_ovf1;
    logic signed [15:0] out_acc1;

    int tests = 0;
    int fails = 0;

    prod_acc u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_p(in_p), .out_valid(out_valid0), .out_ready(out_ready),
        .out_acc(out_acc0), .out_ovf(out_ovf0)
    );

    prod_acc #(.ACC_W(16), .LEN(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_p(in_p), .out_valid(out_valid1), .out_ready(out_ready),
        .out_acc(out_acc1), .out_ovf(out_ovf1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     p[4];
        longint acc;
        bit     ovf;
    } vec_t;

    function automatic longint acc_of(int sel);
        return sel ? longint'(out_acc1) : longint'(out_acc0);
    endfunction
    function automatic bit ovf_of(int sel);
        return sel ? out_ovf1 : out_ovf0;
    endfunction
    function automatic bit vld_of(int sel);
        return sel ? out_valid1 : out_valid0;
    endfunction
    function automatic bit rdy_of(int sel);
        return sel ? in_ready1 : in_ready0;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer sum, each step checked against the signed range.
    function automatic void model(input int ps[$], input int w,
                                  output longint acc, output bit ovf);
        longint mx, mn, s;
        mx  = (64'sd1 <<< (w - 1)) - 1;
        mn  = -(64'sd1 <<< (w - 1));
        acc = 0;
        ovf = 1'b0;
        foreach (ps[i]) begin
            s = acc + ps[i];
            if (s > mx || s < mn) begin
                ovf = 1'b1;
`ifdef PROD_ACC_SAT_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (64'sd1 <<< w) : s + (64'sd1 <<< w);
`endif
            end
            acc = s;
        end
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        in_p      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Present one product and wait (bounded) until the selected DUT takes it.
    task automatic send(int sel, int p);
        int n = 0;
        in_valid = 1'b1;
        in_p     = 16'(p);
        while (!rdy_of(sel) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Stream a block, check latency, hold the result `hold` cycles while
    // poking in_valid, then consume it.
    task automatic run_block(int sel, int ps[$], bit bubble, int hold,
                             output longint acc, output bit ovf);
        longint first;
        foreach (ps[i]) begin
            if (i == ps.size() - 1) chk("early_valid", vld_of(sel), 0);
            send(sel, ps[i]);
            if (bubble && i != ps.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        chk("valid_latency", vld_of(sel), 1);
        acc   = acc_of(sel);
        ovf   = ovf_of(sel);
        first = acc;
        for (int c = 0; c < hold; c++) begin
            in_valid = c[0];
            in_p     = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", vld_of(sel), 1);
            chk("hold_in_ready", rdy_of(sel), 0);
            chk("hold_acc_stable", acc_of(sel), first);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_xfer", vld_of(sel), 0);
        chk("ready_after_xfer", rdy_of(sel), 1);
    endtask

    initial begin : main
        vec_t   tbl[4];
        int     q[$];
        longint a, ea, a2;
        bit     o, eo, o2;

        tbl[0] = '{'{16384, -16256, -1, 0}, 127, 1'b0};
`ifdef PROD_ACC_SAT_EN
        tbl[1] = '{'{16384, 16384, 16384, 16384}, 32767, 1'b1};
        tbl[2] = '{'{-16256, -16256, -16256, -16256}, -32768, 1'b1};
`else
        tbl[1] = '{'{16384, 16384, 16384, 16384}, 0, 1'b1};
        tbl[2] = '{'{-16256, -16256, -16256, -16256}, 512, 1'b1};
`endif
        tbl[3] = '{'{100, -200, 300, -400}, -200, 1'b0};

        // Reset values, checked while reset is held.
        in_valid = 1'b0; in_p = '0; out_ready = 1'b0; rst_n = 1'b0;
        #3;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_acc", acc_of(0), 0);
        chk("rst_out_ovf", out_ovf0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready0, 1);

        // 16 x 100 unbroken stream.
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(100);
        run_block(0, q, 1'b0, 0, a, o);
        chk("stream_acc", a, 1600);
        chk("stream_ovf", o, 0);

        // Directed table on the short-block instance.
        foreach (tbl[k]) begin
            do_reset();
            q = {};
            foreach (tbl[k].p[j]) q.push_back(tbl[k].p[j]);
            run_block(1, q, 1'b0, 0, a, o);
            chk($sformatf("tbl%0d_acc", k), a, tbl[k].acc);
            chk($sformatf("tbl%0d_ovf", k), o, tbl[k].ovf);
        end

        // Backpressure: 5 held cycles with in_valid pulses, then a clean block.
        do_reset();
        run_block(1, '{1, 2, 3, 4}, 1'b0, 5, a, o);
        chk("bp_acc", a, 10);
        run_block(1, '{5, 5, 5, 5}, 1'b0, 0, a, o);
        chk("bp_next_acc", a, 20);
        chk("bp_next_ovf", o, 0);

        // Bubbles: same stream with and without gaps.
        do_reset();
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(0, 32640)) - 16256);
        model(q, 24, ea, eo);
        run_block(0, q, 1'b0, 0, a, o);
        run_block(0, q, 1'b1, 0, a2, o2);
        chk("bubble_ref_acc", a, ea);
        chk("bubble_acc", a2, ea);
        chk("bubble_ovf", o2, eo);

        // Reset mid-block, then reset while a result is held.
        do_reset();
        for (int i = 0; i < 3; i++) send(0, 1000);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid0, 0);
        chk("midrst_acc", acc_of(0), 0);
        chk("midrst_ovf", out_ovf0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(0, 7);
        chk("pre_rst_hold", out_valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("holdrst_valid", out_valid0, 0);
        chk("holdrst_acc", acc_of(0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(1);
        run_block(0, q, 1'b0, 0, a, o);
        chk("postrst_acc", a, 16);
        chk("postrst_ovf", o, 0);

        // Randomized blocks on both instances against the model.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            int sel;
            int len;
            sel = k % 2;
            len = sel ? 4 : 16;
            if (sel == 0 && k > 0) do_reset();
            if (sel == 1) do_reset();
            q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0)
                    q.push_back(($urandom_range(0, 1) == 1) ? 16384 : -16256);
                else
                    q.push_back(int'($urandom_range(0, 32640)) - 16256);
            end
            model(q, sel ? 16 : 24, ea, eo);
            run_block(sel, q, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), a, o);
            chk($sformatf("rand%0d_acc", k), a, ea);
            chk($sformatf("rand%0d_ovf", k), o, eo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
